// File: rtl/huil_volume_venster_if.sv
`default_nettype none
// ============================================================================
//  Module   : huil_volume_venster_if
//  Purpose  : Bundles the sample stream, window control and result signals of
//             the cry-volume window block.
//  Ports    : (interface, no ports)
//             sample_in / sample_valid  - DSP sample and its qualifier
//             window_restart            - synchronous abort of current window
//             threshold                 - cry threshold for the window mean
//             volume_out / peak_out     - mean / max of last completed window
//             volume_valid              - one-cycle update strobe
//             huil_actief               - hysteresis-filtered crying flag
//  Modports : master - sample source / result consumer
//             slave  - the window block itself
//  Revision : 1.0 - initial release
// ============================================================================
interface huil_volume_venster_if #(
  parameter int SAMPLE_W = 8
);
  logic [SAMPLE_W-1:0] sample_in;
  logic                sample_valid;
  logic                window_restart;
  logic [SAMPLE_W-1:0] threshold;
  logic [SAMPLE_W-1:0] volume_out;
  logic [SAMPLE_W-1:0] peak_out;
  logic                volume_valid;
  logic                huil_actief;

  modport master (
    output sample_in,
    output sample_valid,
    output window_restart,
    output threshold,
    input  volume_out,
    input  peak_out,
    input  volume_valid,
    input  huil_actief
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    input  window_restart,
    input  threshold,
    output volume_out,
    output peak_out,
    output volume_valid,
    output huil_actief
  );
endinterface
`default_nettype wire

// File: rtl/huil_volume_venster.sv
`default_nettype none
// ============================================================================
//  Module   : huil_volume_venster
//  Purpose  : Windowed volume meter for the input chain. Averages sample
//             magnitudes over 2^LOG2_WIN accepted samples, tracks the peak of
//             each window, strobes the result once per window and runs a
//             hysteresis FSM that flags sustained crying.
//  Ports    : clk    - system clock, rising edge
//             reset  - asynchronous, active-low reset
//             bus    - huil_volume_venster_if.slave (sample stream, window
//                      restart, threshold, volume/peak results, huil_actief)
//  Options  : HUIL_SIGNED_ABS_EN - when defined, sample_in is two's
//             complement and its absolute value is used as magnitude;
//             otherwise sample_in is taken as an unsigned magnitude.
//  Revision : 1.0 - initial release
// ============================================================================
module huil_volume_venster #(
  parameter int SAMPLE_W     = 8,
  parameter int LOG2_WIN     = 6,
  parameter int HOLD_WINDOWS = 3
) (
  input  wire logic               clk,
  input  wire logic               reset,
  huil_volume_venster_if.slave    bus
);

  // Accumulator holds the full sum of one window: 2^LOG2_WIN samples of at
  // most 2^SAMPLE_W-1 each, so it can never wrap.
  localparam int                  c_ACC_W = SAMPLE_W + LOG2_WIN;
  localparam logic [LOG2_WIN-1:0] c_LAST  = {LOG2_WIN{1'b1}};
  localparam logic [3:0]          c_HOLD  = 4'(HOLD_WINDOWS);

  typedef enum logic [1:0] {
    STIL     = 2'd0,
    STIJGEND = 2'd1,
    HUIL     = 2'd2,
    DALEND   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Magnitude of the incoming sample
  // --------------------------------------------------------------------------
  logic [SAMPLE_W-1:0] w_mag;

`ifdef HUIL_SIGNED_ABS_EN
  // Two's complement negate; the most negative code maps onto itself, which
  // read as unsigned is exactly 2^(SAMPLE_W-1), the correct magnitude.
  assign w_mag = bus.sample_in[SAMPLE_W-1] ? (~bus.sample_in + SAMPLE_W'(1))
                                           : bus.sample_in;
`else
  assign w_mag = bus.sample_in;
`endif

  // --------------------------------------------------------------------------
  // Input stage (edge E)
  // Always captures; a restart only clears the window side, so a sample that
  // arrives together with the restart strobe survives as sample 1.
  // --------------------------------------------------------------------------
  logic                r_in_valid;
  logic [SAMPLE_W-1:0] r_in_mag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_valid <= 1'b0;
      r_in_mag   <= '0;
    end else begin
      r_in_valid <= bus.sample_valid;
      r_in_mag   <= w_mag;
    end
  end

  // --------------------------------------------------------------------------
  // Window accumulation (edge E+1)
  // --------------------------------------------------------------------------
  logic [c_ACC_W-1:0]  r_acc;
  logic [LOG2_WIN-1:0] r_count;
  logic [SAMPLE_W-1:0] r_peak;
  logic [SAMPLE_W-1:0] r_volume;
  logic [SAMPLE_W-1:0] r_peak_out;
  logic                r_volume_valid;

  logic [c_ACC_W-1:0]  w_sum;
  logic [SAMPLE_W-1:0] w_peak_nxt;
  logic [SAMPLE_W-1:0] w_mean;
  logic                w_close;
  logic                w_hi;

  assign w_sum      = r_acc + c_ACC_W'(r_in_mag);
  assign w_peak_nxt = (r_in_mag > r_peak) ? r_in_mag : r_peak;
  // Truncating divide by the window length is just dropping the low bits.
  assign w_mean     = w_sum[c_ACC_W-1:LOG2_WIN];
  // The staged sample is the last one of the window; a coincident restart
  // discards the whole window instead of closing it.
  assign w_close    = r_in_valid && !bus.window_restart && (r_count == c_LAST);
  assign w_hi       = (w_mean >= bus.threshold);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc          <= '0;
      r_count        <= '0;
      r_peak         <= '0;
      r_volume       <= '0;
      r_peak_out     <= '0;
      r_volume_valid <= 1'b0;
    end else begin
      r_volume_valid <= w_close;
      if (bus.window_restart) begin
        r_acc   <= '0;
        r_count <= '0;
        r_peak  <= '0;
      end else if (r_in_valid) begin
        if (w_close) begin
          // Start the next window empty so a back-to-back sample on the
          // following edge becomes its first element.
          r_acc      <= '0;
          r_count    <= '0;
          r_peak     <= '0;
          r_volume   <= w_mean;
          r_peak_out <= w_peak_nxt;
        end else begin
          r_acc   <= w_sum;
          r_count <= r_count + LOG2_WIN'(1);
          r_peak  <= w_peak_nxt;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Hysteresis FSM, advanced only on a window close
  // --------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_hold;
  logic [3:0] w_hold_nxt;
  logic [3:0] w_hold_inc;

  assign w_hold_inc = r_hold + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= STIL;
      r_hold  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    if (w_close) begin
      case (r_state)
        STIL: begin
          if (w_hi) begin
            if (c_HOLD == 4'd1) begin
              w_state_nxt = HUIL;
              w_hold_nxt  = 4'd0;
            end else begin
              w_state_nxt = STIJGEND;
              w_hold_nxt  = 4'd1;
            end
          end
        end
        STIJGEND: begin
          if (w_hi) begin
            if (w_hold_inc == c_HOLD) begin
              w_state_nxt = HUIL;
              w_hold_nxt  = 4'd0;
            end else begin
              w_hold_nxt  = w_hold_inc;
            end
          end else begin
            w_state_nxt = STIL;
            w_hold_nxt  = 4'd0;
          end
        end
        HUIL: begin
          if (!w_hi) begin
            if (c_HOLD == 4'd1) begin
              w_state_nxt = STIL;
              w_hold_nxt  = 4'd0;
            end else begin
              w_state_nxt = DALEND;
              w_hold_nxt  = 4'd1;
            end
          end
        end
        DALEND: begin
          if (!w_hi) begin
            if (w_hold_inc == c_HOLD) begin
              w_state_nxt = STIL;
              w_hold_nxt  = 4'd0;
            end else begin
              w_hold_nxt  = w_hold_inc;
            end
          end else begin
            w_state_nxt = HUIL;
            w_hold_nxt  = 4'd0;
          end
        end
        default: begin
          w_state_nxt = STIL;
          w_hold_nxt  = 4'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.volume_out   = r_volume;
  assign bus.peak_out     = r_peak_out;
  assign bus.volume_valid = r_volume_valid;
  // Decoded from the state register, so it moves in the same cycle as the
  // volume_valid strobe of the window that caused the transition.
  assign bus.huil_actief  = (r_state == HUIL) || (r_state == DALEND);

endmodule
`default_nettype wire

// File: tb/tb_huil_volume_venster.sv
`default_nettype none
// ============================================================================
//  Module   : tb_huil_volume_venster
//  Purpose  : Self-checking bench for huil_volume_venster. A window-level
//             reference model (queue of samples, sum/max, streak counter)
//             predicts every output after each clock edge.
//  Options  : HUIL_SIGNED_ABS_EN - selects the signed-magnitude checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_huil_volume_venster;

  localparam int c_WIN  = 64;
  localparam int c_HOLD = 3;

  logic clk;
  logic rst_n;

  huil_volume_venster_if #(.SAMPLE_W(8)) bus ();

  huil_volume_venster #(
    .SAMPLE_W     (8),
    .LOG2_WIN     (6),
    .HOLD_WINDOWS (c_HOLD)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  // Reference model state
  int win_q[$];
  bit pend_v;
  int pend_d;
  int e_vol;
  int e_peak;
  bit e_vv;
  bit e_act;
  int streak;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int mag_of(input logic [7:0] v);
    int s;
`ifdef HUIL_SIGNED_ABS_EN
    s = int'($signed(v));
    if (s < 0) s = -s;
`else
    s = int'(v);
`endif
    return s;
  endfunction

  task automatic model_reset();
    win_q.delete();
    pend_v = 0; pend_d = 0;
    e_vol = 0; e_peak = 0; e_vv = 0; e_act = 0; streak = 0;
  endtask

  // One clock edge of the behavioural model: the sample seen on the previous
  // edge joins the window now, unless a restart throws the window away.
  task automatic model_edge(input int v, input bit val, input bit rs);
    int sum, mx;
    bit hi;
    e_vv = 0;
    if (rs) begin
      win_q.delete();
    end else if (pend_v) begin
      win_q.push_back(pend_d);
      if (win_q.size() == c_WIN) begin
        sum = 0; mx = 0;
        foreach (win_q[i]) begin
          sum += win_q[i];
          if (win_q[i] > mx) mx = win_q[i];
        end
        e_vol  = sum / c_WIN;
        e_peak = mx;
        e_vv   = 1;
        hi     = (e_vol >= int'(bus.threshold));
        // Flip the flag after c_HOLD consecutive windows that disagree with it.
        if (hi != e_act) streak++;
        else             streak = 0;
        if (streak == c_HOLD) begin
          e_act  = ~e_act;
          streak = 0;
        end
        win_q.delete();
      end
    end
    pend_v = val;
    pend_d = mag_of(8'(v));
  endtask

  task automatic step(input int v, input bit val, input bit rs);
    bus.sample_in      = 8'(v);
    bus.sample_valid   = val;
    bus.window_restart = rs;
    @(posedge clk);
    model_edge(v, val, rs);
    #1;
    chk("volume_valid", 32'(bus.volume_valid), 32'(e_vv));
    chk("volume_out",   32'(bus.volume_out),   32'(e_vol));
    chk("peak_out",     32'(bus.peak_out),     32'(e_peak));
    chk("huil_actief",  32'(bus.huil_actief),  32'(e_act));
    if (bus.volume_valid === 1'b1) pulses++;
    @(negedge clk);
    bus.sample_valid   = 1'b0;
    bus.window_restart = 1'b0;
  endtask

  // 64 samples of one value back to back, then one idle cycle so the result
  // strobe of that window is visible when the task returns.
  task automatic window_const(input int v);
    for (int i = 0; i < c_WIN; i++) step(v, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    rst_n              = 1'b0;
    bus.sample_in      = '0;
    bus.sample_valid   = 1'b0;
    bus.window_restart = 1'b0;
    bus.threshold      = 8'd50;
    #1;
    chk("rst_volume_out",   32'(bus.volume_out),   0);
    chk("rst_peak_out",     32'(bus.peak_out),     0);
    chk("rst_volume_valid", 32'(bus.volume_valid), 0);
    chk("rst_huil_actief",  32'(bus.huil_actief),  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp 0..63 at full rate: mean 2016>>6 = 31, peak 63
    for (int i = 0; i < c_WIN; i++) step(i, 1'b1, 1'b0);
    chk("ramp_no_early_pulse", 32'(bus.volume_valid), 0);
    step(0, 1'b0, 1'b0);
    chk("ramp_pulse",  32'(bus.volume_valid), 1);
    chk("ramp_volume", 32'(bus.volume_out),   31);
    chk("ramp_peak",   32'(bus.peak_out),     63);
    step(0, 1'b0, 1'b0);
    chk("ramp_pulse_one_cycle", 32'(bus.volume_valid), 0);

    // Full-scale window then a window of zeros
    window_const(255);
`ifndef HUIL_SIGNED_ABS_EN
    chk("full_volume", 32'(bus.volume_out), 255);
    chk("full_peak",   32'(bus.peak_out),   255);
`endif
    window_const(0);
    chk("zero_volume", 32'(bus.volume_out), 0);
    chk("zero_peak",   32'(bus.peak_out),   0);

    // Hysteresis entry: means 60,60,40,60,60,60 against threshold 50
    bus.threshold = 8'd50;
    window_const(60); chk("hys_w1", 32'(bus.huil_actief), 0);
    window_const(60); chk("hys_w2", 32'(bus.huil_actief), 0);
    window_const(40); chk("hys_w3", 32'(bus.huil_actief), 0);
    window_const(60); chk("hys_w4", 32'(bus.huil_actief), 0);
    window_const(60); chk("hys_w5", 32'(bus.huil_actief), 0);
    window_const(60); chk("hys_w6", 32'(bus.huil_actief), 1);

    // Asynchronous reset with 30 samples in flight
    for (int i = 0; i < 30; i++) step(77, 1'b1, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_volume_out",   32'(bus.volume_out),   0);
    chk("arst_peak_out",     32'(bus.peak_out),     0);
    chk("arst_volume_valid", 32'(bus.volume_valid), 0);
    chk("arst_huil_actief",  32'(bus.huil_actief),  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulses = 0;
    window_const(10);
    chk("post_rst_volume", 32'(bus.volume_out), 10);
    chk("post_rst_peak",   32'(bus.peak_out),   10);
    chk("post_rst_pulses", 32'(pulses),         1);

    // Hysteresis exit after three quiet windows
    window_const(60); window_const(60); window_const(60);
    chk("hys_up", 32'(bus.huil_actief), 1);
    window_const(10); chk("hys_d1", 32'(bus.huil_actief), 1);
    window_const(10); chk("hys_d2", 32'(bus.huil_actief), 1);
    window_const(10); chk("hys_d3", 32'(bus.huil_actief), 0);

    // Restart after 40 samples, together with a new valid sample
    pulses = 0;
    for (int i = 0; i < 40; i++) step(200, 1'b1, 1'b0);
    step(20, 1'b1, 1'b1);
    for (int i = 0; i < 63; i++) step(20, 1'b1, 1'b0);
    chk("restart_no_pulse", 32'(pulses), 0);
    step(0, 1'b0, 1'b0);
    chk("restart_pulse",  32'(bus.volume_valid), 1);
    chk("restart_volume", 32'(bus.volume_out),   20);
    chk("restart_peak",   32'(bus.peak_out),     20);

    // Restart on the closing edge discards the window
    pulses = 0;
    for (int i = 0; i < c_WIN; i++) step(90, 1'b1, 1'b0);
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b0);
    chk("close_restart_pulses", 32'(pulses),         0);
    chk("close_restart_volume", 32'(bus.volume_out), 20);

`ifdef HUIL_SIGNED_ABS_EN
    for (int i = 0; i < c_WIN; i++) step((i % 2 == 0) ? 8'h9C : 8'd100, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0);
    chk("signed_volume", 32'(bus.volume_out), 100);
    step(8'h80, 1'b1, 1'b0);
    for (int i = 1; i < c_WIN; i++) step(0, 1'b1, 1'b0);
    step(0, 1'b0, 1'b0);
    chk("signed_peak",   32'(bus.peak_out),   128);
    chk("signed_volume2", 32'(bus.volume_out), 2);
`endif

    // Randomised traffic: gaps, back-to-back windows, rare restarts
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) bus.threshold = 8'($urandom_range(90, 165));
      step(int'($urandom_range(0, 255)),
           ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 199) == 0));
    end
    repeat (3) step(0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
